ddr_burst_reader: RTL and testbench
===================================

# ddr_burst_reader

Read-master burst engine between the fill-FIFO address sequencer and the HDMI pixel FIFO. Each `go_fill_fifo` pulse with its `ddr_addr_to_read` becomes one fixed-length master read burst on the bus IPIF. Returned data beats are written into the pixel FIFO under full backpressure. One request is buffered while a burst is in flight; overruns and bus errors are flagged sticky.

## Interface
- `C_BURST_WORDS`, 64: 32-bit words per burst (256 bytes, i.e. half FIFO).
- `C_LENGTH_WIDTH`, 12: width of the byte-length field.

Ports:
- `Bus2IP_Clk` in 1: the only clock.
- `Bus2IP_Resetn` in 1: reset, asynchronous, active-low.
- `go_fill_fifo` in 1: single-cycle burst request.
- `ddr_addr_to_read` in 32: burst byte address, valid with `go_fill_fifo`.
- `flush` in 1: synchronous abort, driven at frame end.
- `IP2Bus_MstRd_Req` out 1: read command request.
- `IP2Bus_Mst_Addr` out 32: command address.
- `IP2Bus_Mst_Length` out C_LENGTH_WIDTH: command byte count, equal to C_BURST_WORDS*4.
- `Bus2IP_Mst_CmdAck` in 1: command accepted.
- `Bus2IP_Mst_Cmplt` in 1: transfer complete.
- `Bus2IP_Mst_Error` in 1: transfer error.
- `Bus2IP_MstRd_d` in 32: read data.
- `Bus2IP_MstRd_src_rdy_n` in 1: data valid, active-low.
- `Bus2IP_MstRd_eof_n` in 1: last beat, active-low.
- `IP2Bus_MstRd_dst_rdy_n` out 1: sink ready, active-low.
- `fifo_full` in 1: pixel FIFO full.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out 32: FIFO write data.
- `busy` out 1: state is not IDLE, or a request is pending.
- `overrun_err` out 1: sticky; set when a request is dropped.
- `rd_error` out 1: sticky; set on bus error or short burst.

## Operation
- **States:**
  - IDLE → CMD on `go_fill_fifo` or a pending request.
  - CMD holds `IP2Bus_MstRd_Req` high until `Bus2IP_Mst_CmdAck`, then goes to DATA.
  - DATA → WAIT_CMPLT on an accepted beat with `eof_n`=0. If `Cmplt` is seen in the same cycle or earlier, DATA skips WAIT_CMPLT.
  - WAIT_CMPLT → CMD if a request is pending, else IDLE.
- **Command registers:**
  - Address and length are latched on entry to CMD.
  - They are held stable until `CmdAck`.
  - `IP2Bus_Mst_Addr[1:0]` is forced to 0.
- **Beat acceptance:**
  - Beat accepted = `src_rdy_n`=0 and `dst_rdy_n`=0.
  - In DATA, `dst_rdy_n` = `fifo_full`. Outside DATA it is 1.
  - `fifo_wr_en` = beat accepted, combinational. `fifo_wr_data` = `Bus2IP_MstRd_d`.
- **Beat counter:**
  - Width is clog2(C_BURST_WORDS)+1; cleared on entering CMD.
  - `eof` arriving with count ≠ C_BURST_WORDS sets `rd_error`.
  - Beats beyond C_BURST_WORDS are accepted but not written.
- **Pending slot (depth 1):**
  - A `go_fill_fifo` while not in IDLE fills the slot (address stored).
  - A `go_fill_fifo` while the slot is already full is dropped and sets `overrun_err`.
  - A `go_fill_fifo` in IDLE with the slot empty goes directly to CMD.
- **Flush:**
  - IDLE: clears the pending slot, `overrun_err` and `rd_error`.
  - CMD before `CmdAck`: drops the request and returns to IDLE next cycle.
  - CMD with `CmdAck` in the same cycle: treated as acked.
  - DATA or WAIT_CMPLT: clears the pending slot and the stickies. The burst drains with `dst_rdy_n`=0 regardless of `fifo_full`, and `fifo_wr_en` is held 0 until IDLE.
- **Bus error:** `Bus2IP_Mst_Error` in any non-IDLE state sets `rd_error`. It does not change state.
- **Simultaneous events:** `flush` together with `go_fill_fifo` means flush wins and the request is discarded.

## Timing
- **Reset values:** state IDLE, `IP2Bus_MstRd_Req`=0, `IP2Bus_Mst_Addr`=0, `IP2Bus_Mst_Length`=C_BURST_WORDS*4, `IP2Bus_MstRd_dst_rdy_n`=1, `fifo_wr_en`=0, `busy`=0, `overrun_err`=0, `rd_error`=0, pending slot empty.
- **Request latency:** `go_fill_fifo` at edge N → `IP2Bus_MstRd_Req`=1 from edge N+1.
- **Ack:** `CmdAck` at edge M → Req=0 and state DATA from edge M+1.
- **Back-to-back:** with a pending request, `Cmplt` at edge K → Req=1 from edge K+1, with no IDLE cycle.
- **FIFO write path:** zero latency from beat to `fifo_wr_en`. Backpressure is immediate via combinational `dst_rdy_n`.

## Configuration
- `DDR_BURST_READER_BYTESWAP_EN` defined: `fifo_wr_data` = `Bus2IP_MstRd_d` byte-reversed ({d[7:0], d[15:8], d[23:16], d[31:24]}).
- Not defined: data passes unchanged.

## Structure
- **Shared package `hdmi_out_pkg`:** state encoding (IDLE=2'd0, CMD=2'd1, DATA=2'd2, WAIT_CMPLT=2'd3), the BYTES_PER_WORD=4 constant, and the default burst length. The fill-FIFO sequencer imports the same package for its HALF_FIFO increment.
- **Sub-module:** one natural sub-module, `ddr_burst_pending_slot`: the depth-1 request buffer producing the overrun flag.

## Test plan
1. Single burst: go with addr=0x1000 → Req with Addr=0x1000, Length=256. Ack after 3 cycles; 64 beats with eof on the last → 64 `fifo_wr_en`; `Cmplt` → IDLE, `busy`=0.
2. Backpressure: `fifo_full`=1 for beats 10–20 → `dst_rdy_n`=1 during that window. Exactly 64 writes in order, no data loss.
3. Pending and overrun:
   - go(0x1000), then go(0x1100) during DATA → second burst starts the cycle after `Cmplt`.
   - A third go while the slot is full → `overrun_err`=1.
4. Short burst: eof on beat 40 → `rd_error`=1, 40 writes, return to IDLE after `Cmplt`.
5. Flush mid-DATA at beat 30 → no further `fifo_wr_en`, remaining beats drained with `dst_rdy_n`=0 despite `fifo_full`=1, pending request discarded, IDLE after `Cmplt`.
6. Async reset asserted in DATA → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hdmi_out_pkg.sv
// hdmi_out_pkg: definitions shared by the HDMI output read path.
//   - FSM state encoding for ddr_burst_reader (legacy 2-bit codes)
//   - BYTES_PER_WORD, DEFAULT_BURST_WORDS (the fill-FIFO sequencer also
//     uses these for its HALF_FIFO address increment)
//   - byte_swap32 helper for the optional byte-reversed FIFO write path
package hdmi_out_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_CMD        = 2'd1;
    localparam state_t ST_DATA       = 2'd2;
    localparam state_t ST_WAIT_CMPLT = 2'd3;

    localparam int unsigned BYTES_PER_WORD      = 4;
    localparam int unsigned DEFAULT_BURST_WORDS = 64;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ddr_burst_pending_slot.sv
// ddr_burst_pending_slot: depth-1 buffer for a burst request that arrives
// while the reader is busy.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       store addr_i (drop and flag overrun if already full)
//   pop_i        consume the stored request this cycle
//   clr_i        empty the slot and clear the overrun flag
//   addr_i       request address to store
//   full_o       slot holds a request
//   addr_o       stored request address
//   overrun_o    sticky: a request was dropped because the slot was full
module ddr_burst_pending_slot
    import hdmi_out_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clr_i,
    input  logic [31:0] addr_i,
    output logic        full_o,
    output logic [31:0] addr_o,
    output logic        overrun_o
);

    logic        full_q, full_d;
    logic [31:0] addr_q, addr_d;
    logic        ovr_q,  ovr_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        ovr_d  = ovr_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            // A push in the same cycle as a pop takes over the freed slot.
            if (full_q && !pop_i) begin
                ovr_d = 1'b1;
            end else begin
                full_d = 1'b1;
                addr_d = addr_i;
            end
        end
        if (clr_i) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign full_o    = full_q;
    assign addr_o    = addr_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/ddr_burst_reader.sv
// ddr_burst_reader: turns each go_fill_fifo request into one fixed-length
// IPIF master read burst and writes the returned beats into the pixel FIFO.
// Optional feature: define DDR_BURST_READER_BYTESWAP_EN to byte-reverse
// each word written to the FIFO.
// Ports:
//   Bus2IP_Clk, Bus2IP_Resetn          clock, async active-low reset
//   go_fill_fifo, ddr_addr_to_read     burst request and its byte address
//   flush                              synchronous abort (frame end)
//   IP2Bus_MstRd_Req/_Mst_Addr/_Mst_Length, Bus2IP_Mst_CmdAck   command
//   Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error transfer status
//   Bus2IP_MstRd_d/_src_rdy_n/_eof_n, IP2Bus_MstRd_dst_rdy_n     data
//   fifo_full, fifo_wr_en, fifo_wr_data                         pixel FIFO
//   busy, overrun_err, rd_error                                 status
module ddr_burst_reader
    import hdmi_out_pkg::*;
#(
    parameter int unsigned C_BURST_WORDS  = DEFAULT_BURST_WORDS,
    parameter int unsigned C_LENGTH_WIDTH = 12
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Resetn,
    input  logic                      go_fill_fifo,
    input  logic [31:0]               ddr_addr_to_read,
    input  logic                      flush,
    output logic                      IP2Bus_MstRd_Req,
    output logic [31:0]               IP2Bus_Mst_Addr,
    output logic [C_LENGTH_WIDTH-1:0] IP2Bus_Mst_Length,
    input  logic                      Bus2IP_Mst_CmdAck,
    input  logic                      Bus2IP_Mst_Cmplt,
    input  logic                      Bus2IP_Mst_Error,
    input  logic [31:0]               Bus2IP_MstRd_d,
    input  logic                      Bus2IP_MstRd_src_rdy_n,
    input  logic                      Bus2IP_MstRd_eof_n,
    output logic                      IP2Bus_MstRd_dst_rdy_n,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [31:0]               fifo_wr_data,
    output logic                      busy,
    output logic                      overrun_err,
    output logic                      rd_error
);

    localparam int unsigned CNT_W = $clog2(C_BURST_WORDS) + 1;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(C_BURST_WORDS);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmplt_seen_q, cmplt_seen_d;
    logic             flushing_q, flushing_d;
    logic             rd_err_q, rd_err_d;

    logic             pend_full, pend_push, pend_pop;
    logic [31:0]      pend_addr;
    logic             clr_sticky;
    logic             launch_ok, launch, take_go;
    logic             in_data, beat_acc, eof_acc;
    logic [CNT_W-1:0] cnt_inc;

    assign in_data = (state_q == ST_DATA);

    // While draining after a flush the bus is always sunk, whatever the FIFO says.
    assign IP2Bus_MstRd_dst_rdy_n = in_data ? (fifo_full & ~flushing_q & ~flush) : 1'b1;
    assign beat_acc = ~Bus2IP_MstRd_src_rdy_n & ~IP2Bus_MstRd_dst_rdy_n;
    assign eof_acc  = beat_acc & ~Bus2IP_MstRd_eof_n;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    assign fifo_wr_en = beat_acc & ~flushing_q & ~flush & (cnt_q < BURST_CNT);

`ifdef DDR_BURST_READER_BYTESWAP_EN
    assign fifo_wr_data = byte_swap32(Bus2IP_MstRd_d);
`else
    assign fifo_wr_data = Bus2IP_MstRd_d;
`endif

    // Flush in CMD only cancels the command; elsewhere it clears slot and stickies.
    assign clr_sticky = flush & (state_q != ST_CMD);

    // A new burst may start from a buffered request or directly from go.
    assign launch_ok = ~flush & (pend_full | go_fill_fifo);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        cmplt_seen_d = cmplt_seen_q;
        flushing_d   = flushing_q;
        rd_err_d     = rd_err_q;
        launch       = 1'b0;

        if (state_q != ST_IDLE && Bus2IP_Mst_Error) begin
            rd_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (launch_ok) begin
                    launch = 1'b1;
                end
            end
            ST_CMD: begin
                if (Bus2IP_Mst_Cmplt) begin
                    cmplt_seen_d = 1'b1;
                end
                if (Bus2IP_Mst_CmdAck) begin
                    req_d   = 1'b0;
                    state_d = ST_DATA;
                end else if (flush) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (flush) begin
                    flushing_d = 1'b1;
                end
                if (Bus2IP_Mst_Cmplt) begin
                    cmplt_seen_d = 1'b1;
                end
                if (beat_acc && cnt_q != '1) begin
                    cnt_d = cnt_inc;
                end
                if (eof_acc) begin
                    if (cnt_inc != BURST_CNT) begin
                        rd_err_d = 1'b1;
                    end
                    if (Bus2IP_Mst_Cmplt || cmplt_seen_q) begin
                        if (launch_ok) begin
                            launch = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT_CMPLT;
                    end
                end
            end
            ST_WAIT_CMPLT: begin
                if (flush) begin
                    flushing_d = 1'b1;
                end
                if (Bus2IP_Mst_Cmplt) begin
                    if (launch_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d      = ST_CMD;
            req_d        = 1'b1;
            addr_d       = {(pend_full ? pend_addr[31:2] : ddr_addr_to_read[31:2]), 2'b00};
            cnt_d        = '0;
            cmplt_seen_d = 1'b0;
        end
        if (state_d == ST_IDLE || launch) begin
            flushing_d = 1'b0;
        end
        if (clr_sticky) begin
            rd_err_d = 1'b0;
        end
    end

    // The buffered request is consumed first; a go arriving at the same time
    // then lands in the freed slot instead of being lost.
    assign pend_pop  = launch & pend_full;
    assign take_go   = launch & ~pend_full;
    assign pend_push = go_fill_fifo & ~flush & ~take_go;

    ddr_burst_pending_slot u_pending (
        .clk       (Bus2IP_Clk),
        .rst_n     (Bus2IP_Resetn),
        .push_i    (pend_push),
        .pop_i     (pend_pop),
        .clr_i     (clr_sticky),
        .addr_i    (ddr_addr_to_read),
        .full_o    (pend_full),
        .addr_o    (pend_addr),
        .overrun_o (overrun_err)
    );

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            cmplt_seen_q <= 1'b0;
            flushing_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            cmplt_seen_q <= cmplt_seen_d;
            flushing_q   <= flushing_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign IP2Bus_MstRd_Req  = req_q;
    assign IP2Bus_Mst_Addr   = addr_q;
    assign IP2Bus_Mst_Length = C_LENGTH_WIDTH'(C_BURST_WORDS * BYTES_PER_WORD);
    assign busy              = (state_q != ST_IDLE) | pend_full;
    assign rd_error          = rd_err_q;

endmodule

// File: tb/tb_ddr_burst_reader.sv
// tb_ddr_burst_reader: directed bench for ddr_burst_reader (default build,
// no byte swap). A negedge monitor records every FIFO write; bus beats carry
// data base+index so order and loss are checked against the bench's own values.
module tb_ddr_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic [31:0] ddr_addr;
    logic        flush;
    logic        req;
    logic [31:0] maddr;
    logic [11:0] mlen;
    logic        ack;
    logic        cmplt;
    logic        merr;
    logic [31:0] rd_d;
    logic        src_rdy_n;
    logic        eof_n;
    logic        dst_rdy_n;
    logic        fifo_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic        ovr;
    logic        rderr;

    int total = 0;
    int bad   = 0;
    logic [31:0] wq[$];

    ddr_burst_reader #(.C_BURST_WORDS(64), .C_LENGTH_WIDTH(12)) dut (
        .Bus2IP_Clk             (clk),
        .Bus2IP_Resetn          (rst_n),
        .go_fill_fifo           (go),
        .ddr_addr_to_read       (ddr_addr),
        .flush                  (flush),
        .IP2Bus_MstRd_Req       (req),
        .IP2Bus_Mst_Addr        (maddr),
        .IP2Bus_Mst_Length      (mlen),
        .Bus2IP_Mst_CmdAck      (ack),
        .Bus2IP_Mst_Cmplt       (cmplt),
        .Bus2IP_Mst_Error       (merr),
        .Bus2IP_MstRd_d         (rd_d),
        .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
        .Bus2IP_MstRd_eof_n     (eof_n),
        .IP2Bus_MstRd_dst_rdy_n (dst_rdy_n),
        .fifo_full              (fifo_full),
        .fifo_wr_en             (wr_en),
        .fifo_wr_data           (wr_data),
        .busy                   (busy),
        .overrun_err            (ovr),
        .rd_error               (rderr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wq.push_back(wr_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_req(input logic [31:0] a);
        go = 1'b1;
        ddr_addr = a;
        step();
        go = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic cmplt_pulse();
        cmplt = 1'b1;
        step();
        cmplt = 1'b0;
    endtask

    // Presents n beats (eof on the last). fifo_full is held for cycles
    // full_lo..full_hi; flush_at >= 0 inserts a flush-only cycle at that cycle
    // index, after which fifo_full stays high for the rest of the burst.
    task automatic run_beats(input int n, input logic [31:0] base,
                             input int full_lo, input int full_hi,
                             input int flush_at, input logic cmplt_on_eof);
        int   i = 0;
        int   cyc = 0;
        logic flushed = 1'b0;
        logic acc;
        logic exp_rdy_n;
        wq.delete();
        while (i < n && cyc < 1000) begin
            if (flush_at >= 0 && cyc == flush_at && !flushed) begin
                src_rdy_n = 1'b1;
                flush = 1'b1;
                step();
                flush = 1'b0;
                flushed = 1'b1;
            end else begin
                src_rdy_n = 1'b0;
                rd_d = base + 32'(i);
                eof_n = (i == n - 1) ? 1'b0 : 1'b1;
                cmplt = (i == n - 1) && cmplt_on_eof;
                fifo_full = flushed || (cyc >= full_lo && cyc <= full_hi);
                #1;
                exp_rdy_n = fifo_full && !flushed;
                check("dst_rdy_n", {31'd0, dst_rdy_n}, {31'd0, exp_rdy_n});
                acc = (dst_rdy_n == 1'b0);
                step();
                if (acc) i++;
            end
            cyc++;
        end
        src_rdy_n = 1'b1;
        eof_n = 1'b1;
        cmplt = 1'b0;
        fifo_full = 1'b0;
        check("beats_done", 32'(i), 32'(n));
    endtask

    task automatic check_writes(input int n, input logic [31:0] base);
        check("nwr", 32'(wq.size()), 32'(n));
        for (int k = 0; k < wq.size() && k < n; k++) begin
            check("wr_data", wq[k], base + 32'(k));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        go = 1'b0; ddr_addr = '0; flush = 1'b0;
        ack = 1'b0; cmplt = 1'b0; merr = 1'b0;
        rd_d = '0; src_rdy_n = 1'b1; eof_n = 1'b1; fifo_full = 1'b0;
        #3;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_addr", maddr, 32'd0);
        check("rst_len", {20'd0, mlen}, 32'd256);
        check("rst_dst_rdy_n", {31'd0, dst_rdy_n}, 32'd1);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        check("rst_rderr", {31'd0, rderr}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: single burst, ack three cycles after the request
        go_req(32'h0000_1000);
        check("t1_req", {31'd0, req}, 32'd1);
        check("t1_addr", maddr, 32'h0000_1000);
        check("t1_len", {20'd0, mlen}, 32'd256);
        check("t1_busy", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("t1_req_hold", {31'd0, req}, 32'd1);
            check("t1_addr_hold", maddr, 32'h0000_1000);
        end
        ack_pulse();
        check("t1_req_after_ack", {31'd0, req}, 32'd0);
        run_beats(64, 32'hA000_0000, -1, -1, -1, 1'b0);
        check_writes(64, 32'hA000_0000);
        check("t1_busy_wait", {31'd0, busy}, 32'd1);
        check("t1_rderr", {31'd0, rderr}, 32'd0);
        cmplt_pulse();
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: backpressure window in the middle of the burst
        go_req(32'h0000_2003);
        check("t2_addr_align", maddr, 32'h0000_2000);
        ack_pulse();
        run_beats(64, 32'hB000_0000, 10, 20, -1, 1'b0);
        check_writes(64, 32'hB000_0000);
        cmplt_pulse();
        check("t2_busy_idle", {31'd0, busy}, 32'd0);

        // 3: pending request, overrun, back-to-back start, cmplt with eof
        go_req(32'h0000_1000);
        ack_pulse();
        go_req(32'h0000_1100);
        check("t3_ovr_first", {31'd0, ovr}, 32'd0);
        go_req(32'h0000_1200);
        check("t3_ovr_set", {31'd0, ovr}, 32'd1);
        run_beats(64, 32'hC000_0000, -1, -1, -1, 1'b0);
        check_writes(64, 32'hC000_0000);
        check("t3_req_wait", {31'd0, req}, 32'd0);
        cmplt_pulse();
        check("t3_b2b_req", {31'd0, req}, 32'd1);
        check("t3_b2b_addr", maddr, 32'h0000_1100);
        ack_pulse();
        run_beats(64, 32'hC100_0000, -1, -1, -1, 1'b1);
        check_writes(64, 32'hC100_0000);
        check("t3_busy_skip_wait", {31'd0, busy}, 32'd0);
        check("t3_ovr_sticky", {31'd0, ovr}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_ovr_cleared", {31'd0, ovr}, 32'd0);

        // 4: short burst, eof on beat 40
        go_req(32'h0000_4000);
        ack_pulse();
        run_beats(40, 32'hD000_0000, -1, -1, -1, 1'b0);
        check_writes(40, 32'hD000_0000);
        check("t4_rderr", {31'd0, rderr}, 32'd1);
        check("t4_busy_wait", {31'd0, busy}, 32'd1);
        cmplt_pulse();
        check("t4_busy_idle", {31'd0, busy}, 32'd0);
        check("t4_rderr_sticky", {31'd0, rderr}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_rderr_cleared", {31'd0, rderr}, 32'd0);

        // 5: bus error in CMD, then flush mid-DATA with a pending request
        go_req(32'h0000_5000);
        merr = 1'b1;
        step();
        merr = 1'b0;
        check("t5_merr", {31'd0, rderr}, 32'd1);
        check("t5_req_held", {31'd0, req}, 32'd1);
        ack_pulse();
        go_req(32'h0000_5100);
        check("t5_busy", {31'd0, busy}, 32'd1);
        run_beats(64, 32'hE000_0000, -1, -1, 30, 1'b0);
        check_writes(30, 32'hE000_0000);
        check("t5_rderr_flushed", {31'd0, rderr}, 32'd0);
        cmplt_pulse();
        check("t5_busy_idle", {31'd0, busy}, 32'd0);
        step();
        check("t5_no_pending", {31'd0, req}, 32'd0);

        // 6: asynchronous reset while a beat is being written
        go_req(32'h0000_6000);
        ack_pulse();
        src_rdy_n = 1'b0;
        rd_d = 32'h1234_5678;
        #1;
        check("t6_wr_before", {31'd0, wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req", {31'd0, req}, 32'd0);
        check("t6_addr", maddr, 32'd0);
        check("t6_len", {20'd0, mlen}, 32'd256);
        check("t6_dst_rdy_n", {31'd0, dst_rdy_n}, 32'd1);
        check("t6_wr_en", {31'd0, wr_en}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ovr", {31'd0, ovr}, 32'd0);
        check("t6_rderr", {31'd0, rderr}, 32'd0);
        src_rdy_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
